sa_ax_channel: RTL
==================

Name: sa_ax_channel

Overview:
- Slave-side Ax channel arbiter (write or read address) for one slave port of the AXI4 interconnect.
- Collects Ax requests from MST_AMT master-side dispatchers and arbitrates them round-robin.
- Forwards each granted request to the slave through a one-entry output register.
- Records the order of granted masters so that the slave-side xDATA path can route write beats back to the right master.

Parameters:
MST_AMT, 2, number of master-side dispatchers competing for this slave
MST_ID_W, $clog2(MST_AMT), width of the granted master index
OUTSTANDING_AMT, 8, depth of the grant-order FIFO
OUTST_CTN_W, $clog2(OUTSTANDING_AMT)+1, width of the outstanding counter
ADDR_WIDTH, 32, address width
TRANS_MST_ID_W, 5, master transaction ID width
TRANS_SLV_ID_W, TRANS_MST_ID_W+MST_ID_W, ID width presented to the slave
TRANS_BURST_W, 2, width of xBURST
TRANS_DATA_LEN_W, 3, width of xLEN
TRANS_DATA_SIZE_W, 3, width of xSIZE

Ports:
ACLK_i  in  1  clock
ARESETn_i  in  1  reset; asynchronous assert, active-low (the clock and the reset are this block's only clock and reset)
m_AxID_i  in  TRANS_MST_ID_W*MST_AMT  per-master AxID, packed with master m at slice m
m_AxADDR_i  in  ADDR_WIDTH*MST_AMT  per-master AxADDR
m_AxBURST_i  in  TRANS_BURST_W*MST_AMT  per-master AxBURST
m_AxLEN_i  in  TRANS_DATA_LEN_W*MST_AMT  per-master AxLEN
m_AxSIZE_i  in  TRANS_DATA_SIZE_W*MST_AMT  per-master AxSIZE
m_AxVALID_i  in  MST_AMT  per-master request valid
m_AxREADY_o  out  MST_AMT  per-master accept (one-hot or zero)
s_AxID_o  out  TRANS_SLV_ID_W  {granted master index, AxID}
s_AxADDR_o  out  ADDR_WIDTH  forwarded address
s_AxBURST_o  out  TRANS_BURST_W  forwarded burst
s_AxLEN_o  out  TRANS_DATA_LEN_W  forwarded length
s_AxSIZE_o  out  TRANS_DATA_SIZE_W  forwarded size
s_AxVALID_o  out  1  slave request valid
s_AxREADY_i  in  1  slave accept
s_xVALID_i  in  1  slave-side data-beat valid (observed only)
s_xREADY_i  in  1  slave-side data-beat ready (observed only)
sa_Ax_outst_ctn_o  out  OUTST_CTN_W  grant-order FIFO occupancy
dsp_xDATA_mst_id_o  out  MST_ID_W  master that owns the current data burst
dsp_xDATA_disable_o  out  1  high when the grant-order FIFO is empty

Behaviour:
Reset:
- ARESETn_i low asynchronously clears all state: s_AxVALID_o=0, all s_Ax* data outputs 0, round-robin pointer=0, beat counter=0, FIFO empty.
- During and after reset: m_AxREADY_o=0, sa_Ax_outst_ctn_o=0, dsp_xDATA_disable_o=1, dsp_xDATA_mst_id_o=0.

Arbitration:
- Combinational round-robin. Search m_AxVALID_i starting at the pointer, wrapping at MST_AMT; the first valid index is the grant g.
- slot_free = ~s_AxVALID_o | (s_AxVALID_o & s_AxREADY_i).
- accept = (any m_AxVALID_i) & slot_free & ~fifo_full.
- m_AxREADY_o[g] = accept; every other bit is 0.
- m_AxREADY_o never depends on s_AxREADY_i when the slot is empty.
- On accept, the pointer becomes (g+1) mod MST_AMT. With no accept, the pointer holds.

Output register:
- On accept: load {g, AxID[g]}, ADDR, BURST, LEN and SIZE of master g, and set s_AxVALID_o=1. Latency is one cycle from master handshake to slave valid.
- On slave handshake without a new accept: clear s_AxVALID_o. Data may hold.
- Back-to-back: a slave handshake and a new accept in the same cycle reload the register and keep s_AxVALID_o=1, giving full throughput.
- While s_AxVALID_o=1 and s_AxREADY_i=0, the register contents are stable (AXI rule).

Grant-order FIFO:
- Depth OUTSTANDING_AMT, width MST_ID_W+TRANS_DATA_LEN_W.
- Push {g, LEN} on accept.
- The head supplies dsp_xDATA_mst_id_o and head_len.
- Pop on beat handshake (s_xVALID_i & s_xREADY_i) when beat counter == head_len.
- fifo_full is evaluated from the occupancy at the start of the cycle. A push is refused when full even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full: occupancy is unchanged.

Beat counter:
- TRANS_DATA_LEN_W bits, advances only on a beat handshake.
- Next value = 0 if counter == head_len, else counter + 1.
- Beat handshakes while the FIFO is empty are illegal upstream. The counter and FIFO ignore them (no pop, no increment).

Reset mid-operation:
- All state is discarded. In-flight requests and order entries are lost, and no output glitches high.

Test Plan:
- Single master: M0 sends ADDR=0x0000_1000, ID=3, LEN=0 with s_AxREADY_i=1 → m_AxREADY_o=01 in the same cycle; next cycle s_AxVALID_o=1, s_AxID_o={0,5'd3}; occupancy 1, mst_id=0; one beat pops it and disable returns to 1.
- Round-robin fairness: M0 and M1 hold valid continuously with s_AxREADY_i=1 → grants alternate 0,1,0,1; s_AxID_o upper bit toggles each cycle.
- Backpressure: s_AxREADY_i=0 for 5 cycles → s_Ax* outputs stable, m_AxREADY_o=00 after the first accept; on ready, the next request is accepted in the same cycle.
- Order and length: M1 issues LEN=3, then M0 issues LEN=1 → mst_id=1 for 4 beats, then 0 for 2 beats, then disable=1.
- FIFO full: 8 accepts with no beats → occupancy 8 and m_AxREADY_o=00 with requests pending; a last-beat pop occurs while M0 is still requesting → that cycle's push is refused (occupancy 7); M0 is accepted the following cycle, occupancy 8.
- Async reset with s_AxVALID_o=1 and occupancy 3 → outputs clear immediately without waiting for a clock edge; disable=1; the pointer restarts at master 0.

Source files
------------

// File: rtl/sa_ax_channel.sv
// Slave-side Ax channel arbiter for one slave port of the AXI4 interconnect.
// Masters are served round-robin. Each granted request goes to the slave
// through a one-entry register. The order of granted masters, together with
// each burst length, is queued so the data path can route beats back to the
// master that owns them.
module sa_ax_channel #(
    parameter int MST_AMT           = 2,
    parameter int MST_ID_W          = $clog2(MST_AMT),
    parameter int OUTSTANDING_AMT   = 8,
    parameter int OUTST_CTN_W       = $clog2(OUTSTANDING_AMT) + 1,
    parameter int ADDR_WIDTH        = 32,
    parameter int TRANS_MST_ID_W    = 5,
    parameter int TRANS_SLV_ID_W    = TRANS_MST_ID_W + MST_ID_W,
    parameter int TRANS_BURST_W     = 2,
    parameter int TRANS_DATA_LEN_W  = 3,
    parameter int TRANS_DATA_SIZE_W = 3
) (
    input  logic                                   ACLK_i,
    input  logic                                   ARESETn_i,
    input  logic [TRANS_MST_ID_W*MST_AMT-1:0]      m_AxID_i,
    input  logic [ADDR_WIDTH*MST_AMT-1:0]          m_AxADDR_i,
    input  logic [TRANS_BURST_W*MST_AMT-1:0]       m_AxBURST_i,
    input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]    m_AxLEN_i,
    input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]   m_AxSIZE_i,
    input  logic [MST_AMT-1:0]                     m_AxVALID_i,
    output logic [MST_AMT-1:0]                     m_AxREADY_o,
    output logic [TRANS_SLV_ID_W-1:0]              s_AxID_o,
    output logic [ADDR_WIDTH-1:0]                  s_AxADDR_o,
    output logic [TRANS_BURST_W-1:0]               s_AxBURST_o,
    output logic [TRANS_DATA_LEN_W-1:0]            s_AxLEN_o,
    output logic [TRANS_DATA_SIZE_W-1:0]           s_AxSIZE_o,
    output logic                                   s_AxVALID_o,
    input  logic                                   s_AxREADY_i,
    input  logic                                   s_xVALID_i,
    input  logic                                   s_xREADY_i,
    output logic [OUTST_CTN_W-1:0]                 sa_Ax_outst_ctn_o,
    output logic [MST_ID_W-1:0]                    dsp_xDATA_mst_id_o,
    output logic                                   dsp_xDATA_disable_o
);

    localparam int PTR_W = (OUTSTANDING_AMT > 1) ? $clog2(OUTSTANDING_AMT) : 1;
    localparam int ORD_W = MST_ID_W + TRANS_DATA_LEN_W;

    logic [MST_ID_W-1:0]         rrPtr;
    logic [MST_ID_W-1:0]         grantIdx;
    logic [MST_ID_W-1:0]         nextPtr;
    logic                        anyValid;
    logic                        slotFree;
    logic                        fifoFull;
    logic                        fifoEmpty;
    logic                        accept;
    logic                        beatHs;
    logic                        pop;
    logic [TRANS_DATA_LEN_W-1:0] beatCnt;
    logic [TRANS_DATA_LEN_W-1:0] headLen;
    logic [MST_ID_W-1:0]         headMst;
    logic [ORD_W-1:0]            orderMem [OUTSTANDING_AMT];
    logic [PTR_W-1:0]            wrPtr;
    logic [PTR_W-1:0]            rdPtr;
    logic [OUTST_CTN_W-1:0]      occCnt;

    // Round-robin search: first valid master at or after the pointer, wrapping.
    always_comb begin
        int idx;
        idx      = 0;
        grantIdx = rrPtr;
        anyValid = 1'b0;
        for (int i = 0; i < MST_AMT; i++) begin
            idx = int'(rrPtr) + i;
            if (idx >= MST_AMT) idx = idx - MST_AMT;
            if (!anyValid && m_AxVALID_i[MST_ID_W'(idx)]) begin
                anyValid = 1'b1;
                grantIdx = MST_ID_W'(idx);
            end
        end
    end

    // Fullness uses start-of-cycle occupancy so a same-cycle pop never frees a slot.
    // Reset gating keeps every master ready low while the block is held in reset.
    assign slotFree  = ~s_AxVALID_o | s_AxREADY_i;
    assign fifoFull  = (occCnt == OUTST_CTN_W'(OUTSTANDING_AMT));
    assign fifoEmpty = (occCnt == '0);
    assign accept    = ARESETn_i & anyValid & slotFree & ~fifoFull;
    assign nextPtr   = (grantIdx == MST_ID_W'(MST_AMT - 1)) ? '0 : grantIdx + MST_ID_W'(1);

    // One-hot accept towards the granted master only.
    always_comb begin
        m_AxREADY_o = '0;
        if (accept) m_AxREADY_o[grantIdx] = 1'b1;
    end

    // Output register and arbitration pointer; holds steady under slave backpressure.
    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            s_AxVALID_o <= 1'b0;
            s_AxID_o    <= '0;
            s_AxADDR_o  <= '0;
            s_AxBURST_o <= '0;
            s_AxLEN_o   <= '0;
            s_AxSIZE_o  <= '0;
            rrPtr       <= '0;
        end else if (accept) begin
            s_AxVALID_o <= 1'b1;
            s_AxID_o    <= {grantIdx, m_AxID_i[grantIdx*TRANS_MST_ID_W +: TRANS_MST_ID_W]};
            s_AxADDR_o  <= m_AxADDR_i[grantIdx*ADDR_WIDTH +: ADDR_WIDTH];
            s_AxBURST_o <= m_AxBURST_i[grantIdx*TRANS_BURST_W +: TRANS_BURST_W];
            s_AxLEN_o   <= m_AxLEN_i[grantIdx*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
            s_AxSIZE_o  <= m_AxSIZE_i[grantIdx*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
            rrPtr       <= nextPtr;
        end else if (s_AxREADY_i) begin
            s_AxVALID_o <= 1'b0;
        end
    end

    // Grant-order head and data-beat bookkeeping; beats with an empty queue are ignored.
    assign headMst = orderMem[rdPtr][ORD_W-1 -: MST_ID_W];
    assign headLen = orderMem[rdPtr][TRANS_DATA_LEN_W-1:0];
    assign beatHs  = s_xVALID_i & s_xREADY_i & ~fifoEmpty;
    assign pop     = beatHs & (beatCnt == headLen);

    // Grant-order storage; contents need no reset since reads are gated by occupancy.
    always_ff @(posedge ACLK_i) begin
        if (accept) begin
            orderMem[wrPtr] <= {grantIdx, m_AxLEN_i[grantIdx*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W]};
        end
    end

    // Grant-order pointers and occupancy; simultaneous push and pop leave occupancy unchanged.
    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            occCnt <= '0;
        end else begin
            if (accept) wrPtr <= (wrPtr == PTR_W'(OUTSTANDING_AMT - 1)) ? '0 : wrPtr + PTR_W'(1);
            if (pop)    rdPtr <= (rdPtr == PTR_W'(OUTSTANDING_AMT - 1)) ? '0 : rdPtr + PTR_W'(1);
            case ({accept, pop})
                2'b10:   occCnt <= occCnt + OUTST_CTN_W'(1);
                2'b01:   occCnt <= occCnt - OUTST_CTN_W'(1);
                default: occCnt <= occCnt;
            endcase
        end
    end

    // Beat counter within the head burst, wrapping to zero on its last beat.
    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            beatCnt <= '0;
        end else if (beatHs) begin
            beatCnt <= (beatCnt == headLen) ? '0 : beatCnt + TRANS_DATA_LEN_W'(1);
        end
    end

    assign sa_Ax_outst_ctn_o   = occCnt;
    assign dsp_xDATA_disable_o = fifoEmpty;
    assign dsp_xDATA_mst_id_o  = fifoEmpty ? '0 : headMst;

endmodule
